// File: rtl/multicycle_main_fsm.sv
// Multicycle main controller: walks each instruction through fetch, decode, execute and
// writeback, emitting raw (unconditioned) write strobes plus datapath mux/enable/ALU controls.
module multicycle_main_fsm #(
    parameter int          STATE_W = 4,
    parameter logic [3:0]  PC_REG  = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic       NoWrite,
    output logic       Illegal
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECR    = STATE_W'(6),
        S_EXECI    = STATE_W'(7),
        S_ALUWB    = STATE_W'(8),
        S_BRANCH   = STATE_W'(9)
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [1:0] alu_ctl_s;
    logic [1:0] alu_fw_s;
    logic       alu_nw_s;

    logic       irwrite_s;
    logic       nextpc_s;
    logic       adrsrc_s;
    logic [1:0] alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] resultsrc_s;
    logic [1:0] aluctl_s;
    logic [1:0] flagw_s;
    logic       regw_s;
    logic       memw_s;
    logic       branch_s;
    logic       nowrite_s;
    logic       illegal_s;

    // State register; reset drops straight to FETCH, aborting any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR:   state_d = S_ALUWB;
            S_EXECI:   state_d = S_ALUWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Data-processing command decode; unsupported commands fall back to a flagless, non-writing ADD.
    always_comb begin
        alu_ctl_s = 2'b00;
        alu_fw_s  = 2'b00;
        alu_nw_s  = 1'b0;
        case (Funct[4:1])
            4'b0100: alu_fw_s = {Funct[0], Funct[0]};
            4'b0010: begin
                alu_ctl_s = 2'b01;
                alu_fw_s  = {Funct[0], Funct[0]};
            end
            4'b0000: begin
                alu_ctl_s = 2'b10;
                alu_fw_s  = {Funct[0], 1'b0};
            end
            4'b1100: begin
                alu_ctl_s = 2'b11;
                alu_fw_s  = {Funct[0], 1'b0};
            end
            4'b1010: begin
                alu_ctl_s = 2'b01;
                alu_fw_s  = {Funct[0], Funct[0]};
                alu_nw_s  = 1'b1;
            end
            default: begin
                alu_ctl_s = 2'b00;
                alu_fw_s  = 2'b00;
                alu_nw_s  = 1'b1;
            end
        endcase
    end

    // Per-state control decode; flags are written only in the execute cycle, never in writeback.
    always_comb begin
        irwrite_s   = 1'b0;
        nextpc_s    = 1'b0;
        adrsrc_s    = 1'b0;
        alusrca_s   = 2'b00;
        alusrcb_s   = 2'b00;
        resultsrc_s = 2'b00;
        aluctl_s    = 2'b00;
        flagw_s     = 2'b00;
        regw_s      = 1'b0;
        memw_s      = 1'b0;
        branch_s    = 1'b0;
        nowrite_s   = 1'b0;
        illegal_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite_s   = 1'b1;
                nextpc_s    = 1'b1;
                alusrca_s   = 2'b01;
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
            end
            S_DECODE: begin
                alusrca_s   = 2'b01;
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
                illegal_s   = (Op == 2'b11);
            end
            S_MEMADR:  alusrcb_s = 2'b01;
            S_MEMREAD: adrsrc_s  = 1'b1;
            S_MEMWB: begin
                resultsrc_s = 2'b01;
                regw_s      = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc_s = 1'b1;
                memw_s   = 1'b1;
            end
            S_EXECR: begin
                aluctl_s  = alu_ctl_s;
                flagw_s   = alu_fw_s;
                nowrite_s = alu_nw_s;
            end
            S_EXECI: begin
                alusrcb_s = 2'b01;
                aluctl_s  = alu_ctl_s;
                flagw_s   = alu_fw_s;
                nowrite_s = alu_nw_s;
            end
            S_ALUWB: begin
                aluctl_s  = alu_ctl_s;
                nowrite_s = alu_nw_s;
                regw_s    = 1'b1;
            end
            S_BRANCH: begin
                alusrcb_s   = 2'b01;
                resultsrc_s = 2'b10;
                branch_s    = 1'b1;
            end
            default: begin
                irwrite_s = 1'b0;
            end
        endcase
    end

    assign IRWrite    = irwrite_s;
    assign NextPC     = nextpc_s;
    assign AdrSrc     = adrsrc_s;
    assign ALUSrcA    = alusrca_s;
    assign ALUSrcB    = alusrcb_s;
    assign ResultSrc  = resultsrc_s;
    assign ALUControl = aluctl_s;
    assign FlagW      = flagw_s;
    assign RegW       = regw_s;
    assign MemW       = memw_s;
    assign PCS        = ((Rd == PC_REG) && regw_s) || branch_s;
    assign NoWrite    = nowrite_s;
    assign Illegal    = illegal_s;

endmodule
